model_stream_sequencer: RTL and testbench

//  Frame-level controller for the model ROM reader. On start it walks models

---
 rtl/render_pkg.sv | 29 ++
 rtl/stream_hold_reg.sv | 37 +++
 rtl/model_stream_sequencer.sv | 158 +++++++++++++++
 tb/tb_model_stream_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/render_pkg.sv
// Shared types for the model stream sequencer: sequencer states and the
// vertex / triangle-index beat formats at their default widths.
package render_pkg;

  localparam int DEF_MODEL_INDEX_WIDTH = 4;
  localparam int DEF_INDEX_ADDR_WIDTH  = 15;
  localparam int DEF_COORDINATE_WIDTH  = 24;

  typedef logic signed [DEF_COORDINATE_WIDTH-1:0] coord_t;
  typedef coord_t [2:0]                           vertex_t;
  typedef logic [2:0][DEF_INDEX_ADDR_WIDTH-1:0]   tri_idx_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_HDR,
    S_V_REQ,
    S_V_WAIT,
    S_V_OUT,
    S_V_ACK,
    S_I_REQ,
    S_I_WAIT,
    S_I_OUT,
    S_I_ACK,
    S_NEXT,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/stream_hold_reg.sv
// Capture/hold register for one output stream: loads a beat plus its last
// flag, presents it as valid, and holds it stable until the consumer accepts.
module stream_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             last,
  output logic             valid
);

  // Beat register: load wins over accept; clear drops an in-flight beat.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      data  <= '0;
      last  <= 1'b0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      last  <= load_last;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/model_stream_sequencer.sv
// Frame-level controller for the model ROM reader: walks a range of models,
// re-arming the reader per model, and drains each model's vertex stream then
// its face-index stream onto two valid/ready output ports.
module model_stream_sequencer
  import render_pkg::*;
#(
  parameter int MODEL_INDEX_WIDTH = DEF_MODEL_INDEX_WIDTH,
  parameter int INDEX_ADDR_WIDTH  = DEF_INDEX_ADDR_WIDTH,
  parameter int COORDINATE_WIDTH  = DEF_COORDINATE_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic [MODEL_INDEX_WIDTH-1:0]          first_model,
  input  logic [MODEL_INDEX_WIDTH:0]            model_count,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  mr_reset,
  output logic [MODEL_INDEX_WIDTH-1:0]          mr_model_index,
  input  logic                                  mr_ready,
  output logic                                  mr_vertex_rd,
  output logic                                  mr_index_rd,
  input  logic [2:0][COORDINATE_WIDTH-1:0]      mr_vertex,
  input  logic                                  mr_vertex_dv,
  input  logic                                  mr_vertex_last,
  input  logic [2:0][INDEX_ADDR_WIDTH-1:0]      mr_index,
  input  logic                                  mr_index_dv,
  input  logic                                  mr_index_last,
  output logic [2:0][COORDINATE_WIDTH-1:0]      vtx_data,
  output logic                                  vtx_valid,
  input  logic                                  vtx_ready,
  output logic                                  vtx_last,
  output logic [2:0][INDEX_ADDR_WIDTH-1:0]      idx_data,
  output logic                                  idx_valid,
  input  logic                                  idx_ready,
  output logic                                  idx_last,
  output logic [MODEL_INDEX_WIDTH-1:0]          cur_model
);

  localparam logic [MODEL_INDEX_WIDTH:0]   REMAIN_ONE = (MODEL_INDEX_WIDTH+1)'(1);
  localparam logic [MODEL_INDEX_WIDTH-1:0] MODEL_ONE  = MODEL_INDEX_WIDTH'(1);

  seq_state_t                   state, state_nxt;
  logic [MODEL_INDEX_WIDTH-1:0] cur_model_q;
  logic [MODEL_INDEX_WIDTH:0]   remaining_q;
  logic                         abort_q;
  logic                         vtx_load, idx_load;
  logic                         walk_accept;

  // A walk with at least one model starts only from IDLE and only without abort.
  assign walk_accept    = (state == S_IDLE) && start && !abort && (model_count != '0);

  assign busy           = (state != S_IDLE) && (state != S_DONE);
  assign done           = (state == S_DONE);
  assign mr_reset       = reset || (state == S_LOAD) || abort_q;
  assign mr_model_index = cur_model_q;
  assign cur_model      = cur_model_q;

  // State, model counter and abort-pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cur_model_q <= '0;
      remaining_q <= '0;
      abort_q     <= 1'b0;
    end else begin
      state   <= state_nxt;
      abort_q <= abort;
      if (walk_accept) begin
        cur_model_q <= first_model;
        remaining_q <= model_count;
      end else if (state == S_NEXT && !abort) begin
        cur_model_q <= cur_model_q + MODEL_ONE;  // wraps modulo 2^MIW
        remaining_q <= remaining_q - REMAIN_ONE;
      end
    end
  end

  // Next-state and reader strobes; abort overrides everything.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt    = state;
    mr_vertex_rd = 1'b0;
    mr_index_rd  = 1'b0;
    vtx_load     = 1'b0;
    idx_load     = 1'b0;
    case (state)
      S_IDLE:     if (start) state_nxt = (model_count != '0) ? S_LOAD : S_DONE;
      S_LOAD:     state_nxt = S_WAIT_HDR;
      S_WAIT_HDR: if (mr_ready) state_nxt = S_V_REQ;
      S_V_REQ: begin
        mr_vertex_rd = 1'b1;
        state_nxt    = S_V_WAIT;
      end
      S_V_WAIT: if (mr_vertex_dv) begin
        vtx_load  = 1'b1;
        state_nxt = S_V_OUT;
      end
      S_V_OUT:    if (vtx_valid && vtx_ready) state_nxt = S_V_ACK;
      S_V_ACK: begin
        mr_vertex_rd = 1'b1;
        state_nxt    = vtx_last ? S_I_REQ : S_V_REQ;
      end
      S_I_REQ: begin
        mr_index_rd = 1'b1;
        state_nxt   = S_I_WAIT;
      end
      S_I_WAIT: if (mr_index_dv) begin
        idx_load  = 1'b1;
        state_nxt = S_I_OUT;
      end
      S_I_OUT:    if (idx_valid && idx_ready) state_nxt = S_I_ACK;
      S_I_ACK: begin
        mr_index_rd = 1'b1;
        state_nxt   = idx_last ? S_NEXT : S_I_REQ;
      end
      S_NEXT:     state_nxt = (remaining_q == REMAIN_ONE) ? S_DONE : S_LOAD;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt    = S_IDLE;
      mr_vertex_rd = 1'b0;
      mr_index_rd  = 1'b0;
      vtx_load     = 1'b0;
      idx_load     = 1'b0;
    end
  end

  stream_hold_reg #(.WIDTH(3*COORDINATE_WIDTH)) u_vtx_hold (
    .clk       (clk),
    .reset     (reset),
    .clear     (abort),
    .load      (vtx_load),
    .load_data (mr_vertex),
    .load_last (mr_vertex_last),
    .ready     (vtx_ready),
    .data      (vtx_data),
    .last      (vtx_last),
    .valid     (vtx_valid)
  );

  stream_hold_reg #(.WIDTH(3*INDEX_ADDR_WIDTH)) u_idx_hold (
    .clk       (clk),
    .reset     (reset),
    .clear     (abort),
    .load      (idx_load),
    .load_data (mr_index),
    .load_last (mr_index_last),
    .ready     (idx_ready),
    .data      (idx_data),
    .last      (idx_last),
    .valid     (idx_valid)
  );

endmodule

// File: tb/tb_model_stream_sequencer.sv
// Self-checking bench: a behavioural model reader serves random per-model
// vertex/face tables; an expected-beat queue built from the model tables is
// compared against every accepted output beat.
module tb_model_stream_sequencer;
  import render_pkg::*;

  localparam int MIW = 4;
  localparam int IAW = 15;
  localparam int CW  = 24;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start, abort;
  logic [MIW-1:0]         first_model;
  logic [MIW:0]           model_count;
  logic                   busy, done, mr_reset;
  logic [MIW-1:0]         mr_model_index;
  logic                   mr_ready;
  logic                   mr_vertex_rd, mr_index_rd;
  vertex_t                mr_vertex, vtx_data;
  logic                   mr_vertex_dv, mr_vertex_last;
  tri_idx_t               mr_index, idx_data;
  logic                   mr_index_dv, mr_index_last;
  logic                   vtx_valid, vtx_ready, vtx_last;
  logic                   idx_valid, idx_ready, idx_last;
  logic [MIW-1:0]         cur_model;

  always #5 clk = ~clk;

  model_stream_sequencer #(
    .MODEL_INDEX_WIDTH (MIW),
    .INDEX_ADDR_WIDTH  (IAW),
    .COORDINATE_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .first_model    (first_model),
    .model_count    (model_count),
    .busy           (busy),
    .done           (done),
    .mr_reset       (mr_reset),
    .mr_model_index (mr_model_index),
    .mr_ready       (mr_ready),
    .mr_vertex_rd   (mr_vertex_rd),
    .mr_index_rd    (mr_index_rd),
    .mr_vertex      (mr_vertex),
    .mr_vertex_dv   (mr_vertex_dv),
    .mr_vertex_last (mr_vertex_last),
    .mr_index       (mr_index),
    .mr_index_dv    (mr_index_dv),
    .mr_index_last  (mr_index_last),
    .vtx_data       (vtx_data),
    .vtx_valid      (vtx_valid),
    .vtx_ready      (vtx_ready),
    .vtx_last       (vtx_last),
    .idx_data       (idx_data),
    .idx_valid      (idx_valid),
    .idx_ready      (idx_ready),
    .idx_last       (idx_last),
    .cur_model      (cur_model)
  );

  // ---------------- model tables and behavioural reader ----------------
  int          nv [16];
  int          nf [16];
  logic [71:0] vmem [16][8];
  logic [71:0] imem [16][8];
  int          hdr_delay = 2;

  logic [3:0]  r_model;
  int          r_vaddr, r_iaddr, r_hdr_cnt;
  logic        r_ready, r_vdv, r_idv;

  always @(posedge clk) begin
    if (mr_reset) begin
      r_model   <= mr_model_index;
      r_vaddr   <= 0;
      r_iaddr   <= 0;
      r_vdv     <= 1'b0;
      r_idv     <= 1'b0;
      r_ready   <= 1'b0;
      r_hdr_cnt <= hdr_delay;
    end else begin
      if (r_hdr_cnt > 0) begin
        r_hdr_cnt <= r_hdr_cnt - 1;
        if (r_hdr_cnt == 1) r_ready <= 1'b1;
      end
      if (mr_vertex_rd) begin
        if (r_vdv) begin
          r_vdv <= 1'b0;
          if (r_vaddr < nv[r_model] - 1) r_vaddr <= r_vaddr + 1;
        end else begin
          r_vdv <= 1'b1;
        end
      end
      if (mr_index_rd) begin
        if (r_idv) begin
          r_idv <= 1'b0;
          if (r_iaddr < nf[r_model] - 1) r_iaddr <= r_iaddr + 1;
        end else begin
          r_idv <= 1'b1;
        end
      end
    end
  end

  assign mr_ready       = r_ready;
  assign mr_vertex      = vmem[r_model][r_vaddr[2:0]];
  assign mr_vertex_dv   = r_vdv;
  assign mr_vertex_last = (r_vaddr == nv[r_model] - 1);
  assign mr_index       = imem[r_model][r_iaddr[2:0]][44:0];
  assign mr_index_dv    = r_idv;
  assign mr_index_last  = (r_iaddr == nf[r_model] - 1);

  // ---------------- reference model and checking ----------------
  typedef struct {
    bit          is_idx;
    logic [3:0]  model;
    logic [71:0] data;
    bit          last;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected beats of a walk straight from the model tables.
  task automatic expect_walk(input int first, input int count);
    beat_t b;
    for (int k = 0; k < count; k++) begin
      int m;
      m = (first + k) % 16;
      for (int v = 0; v < nv[m]; v++) begin
        b.is_idx = 1'b0; b.model = 4'(m); b.data = vmem[m][v]; b.last = (v == nv[m] - 1);
        exp_q.push_back(b);
      end
      for (int f = 0; f < nf[m]; f++) begin
        b.is_idx = 1'b1; b.model = 4'(m); b.data = imem[m][f]; b.last = (f == nf[m] - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic take_beat(input bit is_idx, input logic [71:0] data, input bit last,
                           input logic [3:0] model);
    beat_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_beat", 72'(1), 72'(0));
    end else begin
      e = exp_q.pop_front();
      check("beat_stream", 72'(is_idx), 72'(e.is_idx));
      check("beat_data",   data,        e.data);
      check("beat_last",   72'(last),   72'(e.last));
      check("beat_model",  72'(model),  72'(e.model));
    end
  endtask

  int   cyc = 0, done_cnt = 0, done_cyc = 0, last_idx_cyc = 0;
  int   vtx_beats = 0, all_beats = 0, busy_cyc = 0, rd_cnt = 0, mrr_pulses = 0;
  bit   v_hold, i_hold, abort_prev, mr_reset_prev;
  logic [71:0] v_hold_data, i_hold_data;

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mr_reset && !mr_reset_prev && !reset) mrr_pulses++;
    mr_reset_prev = mr_reset;
    if (reset) begin
      v_hold = 0; i_hold = 0; abort_prev = 0;
    end else begin
      cyc++;
      check("valid_exclusive", 72'(vtx_valid && idx_valid), 72'(0));
      check("rd_exclusive", 72'(mr_vertex_rd && mr_index_rd), 72'(0));
      if (v_hold && !abort_prev) begin
        check("vtx_hold_valid", 72'(vtx_valid), 72'(1));
        check("vtx_hold_data", 72'(vtx_data), v_hold_data);
      end
      if (i_hold && !abort_prev) begin
        check("idx_hold_valid", 72'(idx_valid), 72'(1));
        check("idx_hold_data", {27'd0, idx_data}, i_hold_data);
      end
      if (vtx_valid && vtx_ready) begin
        take_beat(1'b0, 72'(vtx_data), vtx_last, cur_model);
        vtx_beats++; all_beats++;
      end
      if (idx_valid && idx_ready) begin
        take_beat(1'b1, {27'd0, idx_data}, idx_last, cur_model);
        all_beats++;
        if (idx_last) last_idx_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_cyc++;
      if (mr_vertex_rd || mr_index_rd) rd_cnt++;
      v_hold      = vtx_valid && !vtx_ready;
      v_hold_data = 72'(vtx_data);
      i_hold      = idx_valid && !idx_ready;
      i_hold_data = {27'd0, idx_data};
      abort_prev  = abort;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full walk and checks completion; optional stall on vertex beat 1
  // and optional start pulse while busy.
  task automatic do_walk(input int first, input int count, input bit stall,
                         input bit poke_start, input string tag);
    int  d0, vb0;
    bit  stalled;
    d0 = done_cnt; vb0 = vtx_beats; stalled = 0;
    expect_walk(first, count);
    first_model = 4'(first);
    model_count = 5'(count);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
      if (poke_start && i == 10) begin
        first_model = 4'd9; model_count = 5'd4; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (stall && !stalled && vtx_valid && (vtx_beats - vb0) == 1) begin
        vtx_ready = 1'b0;
        repeat (10) tick();
        vtx_ready = 1'b1;
        stalled = 1;
      end
      tick();
    end
    start = 1'b0;
    tick();
    check({tag, "_done_once"}, 72'(done_cnt - d0), 72'(1));
    check({tag, "_queue_empty"}, 72'(exp_q.size()), 72'(0));
    check({tag, "_idle_busy"}, 72'(busy), 72'(0));
  endtask

  initial begin
    logic [95:0] r;
    int b0, d0, rd0, bz0;
    for (int m = 0; m < 16; m++) begin
      nv[m] = $urandom_range(1, 5);
      nf[m] = $urandom_range(1, 4);
      for (int k = 0; k < 8; k++) begin
        r = {$urandom, $urandom, $urandom};
        vmem[m][k] = r[71:0];
        r = {$urandom, $urandom, $urandom};
        imem[m][k] = {27'd0, r[44:0]};
      end
    end
    nv[0] = 3;  nf[0] = 2;
    nv[15] = 1; nf[15] = 1;

    reset = 1'b1; start = 1'b0; abort = 1'b0;
    first_model = '0; model_count = '0;
    vtx_ready = 1'b1; idx_ready = 1'b1;
    repeat (3) tick();
    check("rst_busy", 72'(busy), 72'(0));
    check("rst_done", 72'(done), 72'(0));
    check("rst_vtx_valid", 72'(vtx_valid), 72'(0));
    check("rst_idx_valid", 72'(idx_valid), 72'(0));
    check("rst_lasts", 72'({vtx_last, idx_last}), 72'(0));
    check("rst_rd", 72'({mr_vertex_rd, mr_index_rd}), 72'(0));
    check("rst_data", 72'(vtx_data), 72'(0));
    check("rst_cur_model", 72'(cur_model), 72'(0));
    check("rst_mr_reset", 72'(mr_reset), 72'(1));
    reset = 1'b0;
    tick();
    check("post_rst_mr_reset", 72'(mr_reset), 72'(0));

    // Single model, 3 vertices and 2 faces.
    b0 = all_beats; mrr_pulses = 0;
    do_walk(0, 1, 0, 0, "single");
    check("single_beats", 72'(all_beats - b0), 72'(5));
    check("single_done_latency", 72'(done_cyc - last_idx_cyc), 72'(3));
    check("single_mr_reset_pulses", 72'(mrr_pulses), 72'(1));

    // Three models from 2 with a start pulse while busy (must be ignored).
    mrr_pulses = 0; hdr_delay = 4;
    do_walk(2, 3, 0, 1, "three");
    check("three_mr_reset_pulses", 72'(mrr_pulses), 72'(3));

    // Stall on vertex beat 1.
    hdr_delay = 1;
    do_walk(0, 1, 1, 0, "stall");

    // model_count = 0: immediate done, no activity.
    d0 = done_cnt; rd0 = rd_cnt; bz0 = busy_cyc;
    first_model = 4'd5; model_count = '0; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_done", 72'(done), 72'(1));
    check("zero_busy", 72'(busy), 72'(0));
    tick();
    check("zero_done_pulse", 72'(done), 72'(0));
    repeat (3) tick();
    check("zero_done_count", 72'(done_cnt - d0), 72'(1));
    check("zero_no_rd", 72'(rd_cnt - rd0), 72'(0));
    check("zero_no_busy", 72'(busy_cyc - bz0), 72'(0));

    // Abort while the first model's index beat is held.
    d0 = done_cnt;
    expect_walk(1, 2);
    idx_ready = 1'b0;
    first_model = 4'd1; model_count = 5'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 500 && !idx_valid; i++) tick();
    check("abort_reach_iout", 72'(idx_valid), 72'(1));
    check("abort_model", 72'(cur_model), 72'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 72'(busy), 72'(0));
    check("abort_valids", 72'({vtx_valid, idx_valid}), 72'(0));
    check("abort_mr_reset", 72'(mr_reset), 72'(1));
    tick();
    check("abort_mr_reset_end", 72'(mr_reset), 72'(0));
    repeat (5) tick();
    check("abort_no_done", 72'(done_cnt - d0), 72'(0));
    exp_q.delete();
    idx_ready = 1'b1;
    do_walk(1, 2, 0, 0, "replay");

    // Wrap from model 15 to model 0 with single-beat streams first.
    do_walk(15, 2, 0, 0, "wrap");

    // Simultaneous start and abort in IDLE: abort wins.
    d0 = done_cnt; rd0 = rd_cnt;
    first_model = 4'd3; model_count = 5'd2; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("startabort_busy", 72'(busy), 72'(0));
    repeat (8) tick();
    check("startabort_no_rd", 72'(rd_cnt - rd0), 72'(0));
    check("startabort_no_done", 72'(done_cnt - d0), 72'(0));

    // Reset in mid-walk behaves like power-on reset, no done.
    d0 = done_cnt;
    expect_walk(2, 3);
    first_model = 4'd2; model_count = 5'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    reset = 1'b1;
    repeat (2) tick();
    check("midrst_busy", 72'(busy), 72'(0));
    check("midrst_valids", 72'({vtx_valid, idx_valid}), 72'(0));
    check("midrst_cur_model", 72'(cur_model), 72'(0));
    reset = 1'b0;
    exp_q.delete();
    repeat (6) tick();
    check("midrst_no_done", 72'(done_cnt - d0), 72'(0));
    check("midrst_idle", 72'(busy), 72'(0));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
